// File: rtl/switch_debouncer_if.sv
// Switch-conditioning bundle: raw slide-switch levels in, clean levels,
// edge pulses and qualification status out.
interface switch_debouncer_if #(
  parameter int unsigned N = 6
);

  logic [0:N-1] SW;
  logic [0:N-1] SW_DB;
  logic [0:N-1] SW_RISE;
  logic [0:N-1] SW_FALL;
  logic         CHANGED;
  logic         READY;

  // master drives the raw switches and consumes the conditioned view
  modport master (
    output SW,
    input  SW_DB,
    input  SW_RISE,
    input  SW_FALL,
    input  CHANGED,
    input  READY
  );

  modport slave (
    input  SW,
    output SW_DB,
    output SW_RISE,
    output SW_FALL,
    output CHANGED,
    output READY
  );

endinterface

// File: rtl/switch_debouncer.sv
// Slide-switch conditioner: two-flop synchroniser, per-channel stability counter,
// registered edge pulses gated by a start-up qualification FSM.
module switch_debouncer #(
  parameter int unsigned N             = 6,
  parameter int unsigned STABLE_CYCLES = 500000,
  parameter int unsigned CNT_W         = 19
) (
  input  logic              MAX10_CLK1_50,
  input  logic              RESET_N,
  switch_debouncer_if.slave sw_if
);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  // last count before acceptance, and last init count before going to RUN
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(STABLE_CYCLES + 1);

  logic [0:N-1]     meta_q,   meta_d;
  logic [0:N-1]     sync_q,   sync_d;
  logic [0:N-1]     db_q,     db_d;
  logic [0:N-1]     rise_q,   rise_d;
  logic [0:N-1]     fall_q,   fall_d;
  logic             changed_q, changed_d;
  logic             ready_q,  ready_d;
  logic [CNT_W-1:0] cnt_q [N];
  logic [CNT_W-1:0] cnt_d [N];
  logic [CNT_W-1:0] init_cnt_q, init_cnt_d;
  state_t           state_q,  state_d;

  // ---- synchroniser and per-channel debounce ----
  always_comb begin
    meta_d = sw_if.SW;
    sync_d = meta_q;
    db_d   = db_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < int'(N); i++) begin
      cnt_d[i] = '0;
      if (sync_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          db_d[i] = sync_q[i];
          // acceptance on the INIT->RUN edge still sees ST_INIT here: no pulse
          if (state_q == ST_RUN) begin
            rise_d[i] = sync_q[i];
            fall_d[i] = ~sync_q[i];
          end
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    changed_d = (|rise_d) | (|fall_d);
  end

  // ---- start-up qualification FSM ----
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    ready_d    = ready_q;
    case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == INIT_LAST) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end
      end
      ST_RUN: begin
        ready_d = 1'b1;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      meta_q     <= '0;
      sync_q     <= '0;
      db_q       <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
      changed_q  <= 1'b0;
      ready_q    <= 1'b0;
      init_cnt_q <= '0;
      state_q    <= ST_INIT;
      for (int i = 0; i < int'(N); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      meta_q     <= meta_d;
      sync_q     <= sync_d;
      db_q       <= db_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      changed_q  <= changed_d;
      ready_q    <= ready_d;
      init_cnt_q <= init_cnt_d;
      state_q    <= state_d;
      for (int i = 0; i < int'(N); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // ---- outputs ----
  assign sw_if.SW_DB   = db_q;
  assign sw_if.SW_RISE = rise_q;
  assign sw_if.SW_FALL = fall_q;
  assign sw_if.CHANGED = changed_q;
  assign sw_if.READY   = ready_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: directed start-up/step/bounce/reset scenarios then random
// switch activity, scored cycle-by-cycle against a sliding-window reference model.
module tb_switch_debouncer;

  localparam int N  = 6;
  localparam int S  = 4;
  localparam int CW = 19;

  typedef struct packed {
    logic [0:N-1] db;
    logic [0:N-1] rise;
    logic [0:N-1] fall;
    logic         changed;
    logic         ready;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  switch_debouncer_if #(.N(N)) dut_if ();

  switch_debouncer #(
    .N(N),
    .STABLE_CYCLES(S),
    .CNT_W(CW)
  ) dut (
    .MAX10_CLK1_50(clk),
    .RESET_N(rst_n),
    .sw_if(dut_if)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
  endtask

  // Reference model: SW samples since reset release; a channel flips when the
  // last S synchronised samples all disagree with its current clean level.
  logic [0:N-1] hist[$];
  int           k_edges = 0;
  logic [0:N-1] m_db = '0;
  exp_t         sb_q[$];

  function automatic logic [0:N-1] sync_at(input int m);
    if (m - 2 >= 1) return hist[m - 3];
    return '0;
  endfunction

  always @(posedge clk) begin
    exp_t         e;
    logic [0:N-1] ch;
    logic [0:N-1] smp;
    e = '0;
    if (!rst_n) begin
      k_edges = 0;
      hist.delete();
      m_db = '0;
    end else begin
      k_edges++;
      hist.push_back(dut_if.SW);
      ch = '0;
      if (k_edges >= S) begin
        for (int i = 0; i < N; i++) begin
          ch[i] = 1'b1;
          for (int m = k_edges - S + 1; m <= k_edges; m++) begin
            smp = sync_at(m);
            if (smp[i] == m_db[i]) ch[i] = 1'b0;
          end
        end
      end
      e.db      = m_db ^ ch;
      e.rise    = (k_edges - 1 >= S + 2) ? (ch & e.db) : '0;
      e.fall    = (k_edges - 1 >= S + 2) ? (ch & ~e.db) : '0;
      e.changed = |(e.rise | e.fall);
      e.ready   = (k_edges >= S + 2);
      m_db      = e.db;
    end
    sb_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("SW_DB",   32'(dut_if.SW_DB),   32'(e.db));
      chk("SW_RISE", 32'(dut_if.SW_RISE), 32'(e.rise));
      chk("SW_FALL", 32'(dut_if.SW_FALL), 32'(e.fall));
      chk("CHANGED", 32'(dut_if.CHANGED), 32'(e.changed));
      chk("READY",   32'(dut_if.READY),   32'(e.ready));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic after_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // assert reset off-edge, check async clear, release before the next rising edge
  task automatic do_reset(input logic [0:N-1] sw_val, input int hold);
    @(negedge clk);
    #2 rst_n = 1'b0;
    dut_if.SW = sw_val;
    #1;
    chk("rst_SW_DB",   32'(dut_if.SW_DB),   32'd0);
    chk("rst_READY",   32'(dut_if.READY),   32'd0);
    chk("rst_CHANGED", 32'(dut_if.CHANGED), 32'd0);
    chk("rst_SW_RISE", 32'(dut_if.SW_RISE), 32'd0);
    repeat (hold) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    logic [0:N-1] pat;
    logic [0:N-1] cur;
    int           noisy;
    dut_if.SW = '0;

    // start-up with all switches low: READY exactly 6 clocks after release
    do_reset('0, 2);
    after_edges(5);
    chk("ready_before_6", 32'(dut_if.READY), 32'd0);
    after_edges(1);
    chk("ready_at_6", 32'(dut_if.READY), 32'd1);
    cyc(3);

    // start-up with switches held high: levels appear without pulses
    pat = 6'b101000;
    do_reset(pat, 1);
    after_edges(5);
    chk("held_db_before", 32'(dut_if.SW_DB), 32'd0);
    after_edges(1);
    chk("held_db_at_6", 32'(dut_if.SW_DB), 32'(pat));
    chk("held_no_rise", 32'(dut_if.SW_RISE), 32'd0);
    cyc(4);

    // clean rise then fall on channel 2
    do_reset('0, 1);
    cyc(10);
    dut_if.SW[2] = 1'b1;
    after_edges(6);
    pat = 6'b001000;
    chk("step_rise", 32'(dut_if.SW_RISE), 32'(pat));
    chk("step_changed", 32'(dut_if.CHANGED), 32'd1);
    after_edges(1);
    chk("step_rise_gone", 32'(dut_if.SW_RISE), 32'd0);
    cyc(4);
    dut_if.SW[2] = 1'b0;
    after_edges(6);
    chk("step_fall", 32'(dut_if.SW_FALL), 32'(pat));
    cyc(4);

    // bounce on channel 0: 3-clock pulses never accepted, then a steady hold
    for (int r = 0; r < 5; r++) begin
      dut_if.SW[0] = 1'b1;
      cyc(3);
      dut_if.SW[0] = 1'b0;
      cyc(3);
    end
    chk("bounce_db0", 32'(dut_if.SW_DB), 32'd0);
    dut_if.SW[0] = 1'b1;
    cyc(10);
    dut_if.SW[0] = 1'b0;
    cyc(10);

    // all channels at once
    dut_if.SW = '1;
    after_edges(6);
    chk("all_rise", 32'(dut_if.SW_RISE), 32'h3F);
    chk("all_changed", 32'(dut_if.CHANGED), 32'd1);
    after_edges(1);
    chk("all_rise_gone", 32'(dut_if.SW_RISE), 32'd0);
    cyc(3);
    dut_if.SW = '0;
    cyc(10);

    // partial count on channel 5 aborted by reset, then full re-count without pulse
    dut_if.SW[5] = 1'b1;
    cyc(5);
    do_reset(6'b000001, 1);
    after_edges(5);
    chk("rerun_db_before", 32'(dut_if.SW_DB), 32'd0);
    after_edges(1);
    chk("rerun_db_at_6", 32'(dut_if.SW_DB), 32'd1);
    chk("rerun_no_rise", 32'(dut_if.SW_RISE), 32'd0);
    cyc(5);

    // random switch activity in quiet and noisy phases, rare resets
    cur = '0;
    for (int ph = 0; ph < 60; ph++) begin
      noisy = $urandom_range(0, 2);
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
          if (noisy != 0 && $urandom_range(0, 3 * noisy) == 0) cur[i] = ~cur[i];
        end
        if (noisy == 0 && c == 0) cur = N'($urandom);
        dut_if.SW = cur;
      end
      if ($urandom_range(0, 14) == 0) do_reset(cur, $urandom_range(1, 3));
    end

    cyc(3);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Input-conditioning stage between the DE10-Lite slide switches and the switch-to-LED / switch-to-7-segment display logic.
- Synchronises each raw switch to the board clock and debounces it.
- Produces clean levels plus one-cycle rise/fall pulses, so downstream display and digit logic never sees metastable or bouncing values.
- Includes a start-up qualification phase; edge pulses are suppressed until every channel has settled.

Parameters:
- N, 6, number of switch channels (one per 7-segment display).
- STABLE_CYCLES, 500000, consecutive synchronised cycles a new level must persist before acceptance (10 ms at 50 MHz). Legal range is 2 or more.
- CNT_W, 19, width of per-channel and init counters. Must satisfy 2^CNT_W > STABLE_CYCLES + 2.

Ports:
- MAX10_CLK1_50  input  1  board clock, all logic on rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- SW  input  N, index 0..N-1 ascending  raw slide-switch levels, asynchronous to clock.
- SW_DB  output  N, 0..N-1  debounced switch levels.
- SW_RISE  output  N, 0..N-1  one-cycle pulse when SW_DB[i] goes 0->1.
- SW_FALL  output  N, 0..N-1  one-cycle pulse when SW_DB[i] goes 1->0.
- CHANGED  output  1  OR of all SW_RISE and SW_FALL bits in the same cycle.
- READY  output  1  high once the start-up qualification period has completed.

Behaviour:
- Reset (RESET_N low, asynchronous):
  - Synchroniser flops, SW_DB, SW_RISE, SW_FALL, CHANGED and READY are all 0.
  - All counters are 0; the FSM is in INIT.
  - Reset asserted mid-operation aborts everything immediately: no pulse is emitted and no partially counted change is retained.
- Synchroniser: a two-flop chain per channel. sync[i] lags SW[i] by 2 clocks.
- Per-channel debounce counter cnt[i]:
  - sync[i] == SW_DB[i]: cnt[i] <= 0.
  - sync[i] != SW_DB[i] and cnt[i] < STABLE_CYCLES-1: cnt[i] <= cnt[i]+1.
  - sync[i] != SW_DB[i] and cnt[i] == STABLE_CYCLES-1: SW_DB[i] <= sync[i] and cnt[i] <= 0.
  - Net effect: a level is accepted after exactly STABLE_CYCLES consecutive mismatching cycles.
  - Latency from a clean SW step to the SW_DB change is STABLE_CYCLES+2 clocks.
  - Any return of sync[i] to SW_DB[i] before acceptance clears cnt[i]. A bounce shorter than STABLE_CYCLES synchronised cycles never changes SW_DB.
- Edge pulses:
  - SW_RISE[i] / SW_FALL[i] are registered and assert in the same cycle SW_DB[i] updates.
  - Each pulse is high for exactly one cycle, and only while the FSM is in RUN.
  - Channels are independent. Simultaneous acceptance on several channels gives several pulse bits in one cycle, with CHANGED high for that single cycle.
- FSM, two states:
  - INIT: the init counter increments each cycle. Channels debounce normally, but SW_RISE, SW_FALL and CHANGED are forced to 0. SW_DB still tracks, so switches held high at reset appear on SW_DB without generating pulses. When the init counter reaches STABLE_CYCLES+2, move to RUN and set READY to 1 on that transition edge.
  - RUN: pulses enabled. READY stays 1 until reset. There is no path back to INIT except reset.
- An acceptance on the exact cycle of the INIT->RUN transition is treated as INIT: no pulse.
- Width rules:
  - Counters saturate by construction and never wrap.
  - Counter compares are unsigned at CNT_W bits.
  - N is fixed at elaboration. No reduction or widening of SW is performed.

Test Plan (use STABLE_CYCLES=4, N=6):
- Reset release with SW=6'b000000 held -> SW_DB=0, no pulses, READY rises exactly 6 clocks after RESET_N deasserts.
- Reset release with SW=6'b101000 held -> SW_DB becomes 101000 6 clocks after the first clock edge, SW_RISE and CHANGED stay 0 throughout, then READY=1.
- After READY, SW[2] steps 0->1 cleanly -> SW_DB[2]=1 and SW_RISE=6'b001000 and CHANGED=1 for exactly one cycle, 6 clocks after the step. Later step 1->0 -> SW_FALL=6'b001000 for one cycle.
- After READY, SW[0] toggles high for 3 clocks then low, repeated 5 times (bounce) -> SW_DB[0] stays 0, no pulses. Then hold high 4 clocks -> SW_DB[0]=1 with one SW_RISE[0] pulse.
- After READY, SW steps 000000->111111 in one cycle -> SW_RISE=111111 and CHANGED=1 in a single cycle, then all 0 on the next cycle.
- SW[5] held high 3 clocks post-sync, then RESET_N pulsed low for 1 clock -> all outputs 0 immediately, READY=0. Qualification restarts and SW_DB[5]=1 only after a full re-count, with no pulse.
